// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and line timing helper.
// Imported by both the transmitter and the matching receiver so their bit timing agrees.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Clock cycles per line bit, truncated; callers must ensure the result is at least 2.
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte producer handshake: data qualified by valid, accepted on an edge where ready is high.
// The producer drives data/valid (master); the transmitter returns ready (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered count; full/empty come from the count register only.
// Push is refused when full and pop ignored when empty, regardless of the other side.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  assign rdata = r_mem[r_rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through the reset pointers.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and leave LSB first on tx.
// A queued byte starts one cycle after acceptance; consecutive frames run with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

  uart_state_e               r_state;
  uart_state_e               w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [2:0]                r_idx;
  logic [2:0]                w_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_bit_end;
  logic [UART_DATA_BITS-1:0] w_rdata;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.valid),
    .pop   (w_pop),
    .wdata (bus.data),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.ready = !w_full;
  assign tx        = r_tx;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign w_bit_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // tx is registered from the next-state level so the line changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rdata;
            w_idx_nxt   = '0;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes queue expectations, a mid-bit sampling
// line receiver decodes tx independently and pops/compares each completed frame.
module tb_uart_tx;

  localparam int CLK_FREQ   = 1000000;
  localparam int BAUD_RATE  = 100000;
  localparam int FIFO_DEPTH = 4;
  localparam int BP         = CLK_FREQ / BAUD_RATE;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic busy;

  uart_tx_if u_if ();

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc     = 0;
  int rst_cnt = 0;
  always @(posedge clk)   cyc     <= cyc + 1;
  always @(posedge reset) rst_cnt <= rst_cnt + 1;

  int         n_chk    = 0;
  int         n_pass   = 0;
  int         n_frames = 0;
  logic [7:0] exp_q [$];
  int         starts_q [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle index of the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    int waited;
    waited     = 0;
    u_if.data  = b;
    u_if.valid = 1'b1;
    while (u_if.ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2000) begin
      n_chk++;
      $display("FAIL send_timeout: ready=%b, required 1", u_if.ready);
      acc        = -1;
      u_if.valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      acc        = cyc;
      u_if.valid = 1'b0;
    end
  endtask

  // Reference line receiver: sample each bit at its centre relative to the start edge.
  initial begin : monitor
    int         st;
    int         rc;
    logic [7:0] b;
    logic [7:0] e;
    logic       start_lvl;
    logic       stop_lvl;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        st = cyc;
        rc = rst_cnt;
        starts_q.push_back(st);
        repeat (BP / 2) @(negedge clk);
        start_lvl = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = tx;
        end
        repeat (BP) @(negedge clk);
        stop_lvl = tx;
        if (rc == rst_cnt && !reset) begin
          chk("start_bit", {31'd0, start_lvl}, 32'd0);
          chk("stop_bit", {31'd0, stop_lvl}, 32'd1);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", b);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'd0, b}, {24'd0, e});
            n_frames++;
          end
        end
      end
    end
  end

  initial begin : stim
    int         acc;
    int         s0;
    int         k0;
    int         f0;
    int         lows;
    int         t;
    int         acc_arr [6];
    logic [7:0] fill [6];
    fill = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hC3, 8'h3C};

    u_if.valid = 1'b0;
    u_if.data  = 8'h00;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_ready", {31'd0, u_if.ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte from idle.
    s0 = starts_q.size();
    send(8'hA5, acc);
    wait_until(acc + 100);
    chk("single_busy_before_end", {31'd0, busy}, 32'd1);
    wait_until(acc + 101);
    chk("single_busy_after_end", {31'd0, busy}, 32'd0);
    if (starts_q.size() > s0) chk("single_latency", starts_q[s0] - acc, 32'd1);
    else chk("single_frame_seen", starts_q.size(), s0 + 1);
    repeat (5) @(negedge clk);

    // Fill, full-with-pop refusal and back-to-back stream.
    s0 = starts_q.size();
    k0 = cyc + 1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(fill[i], acc_arr[i]);
      end
      begin
        wait_until(k0 + 4);
        chk("fill_ready_low", {31'd0, u_if.ready}, 32'd0);
        wait_until(k0 + 100);
        chk("ready_low_until_stop_end", {31'd0, u_if.ready}, 32'd0);
        wait_until(k0 + 101);
        chk("ready_recovers_after_pop", {31'd0, u_if.ready}, 32'd1);
      end
    join
    chk("fill_first_accept", acc_arr[0], k0);
    chk("fill_fifth_accept", acc_arr[4] - acc_arr[0], 32'd4);
    chk("full_pop_edge_refused", acc_arr[5] - acc_arr[0], 32'd102);
    wait_until(k0 + 601);
    chk("stream_busy_clear", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 6; j++) begin
      if (starts_q.size() > s0 + j) chk("b2b_start_cycle", starts_q[s0 + j], k0 + 1 + 100 * j);
      else chk("b2b_frame_count", starts_q.size() - s0, j + 1);
    end
    repeat (5) @(negedge clk);

    // Reset during data bit 3 with two bytes queued; bit 3 is forced low so the line is low.
    send(8'($urandom_range(0, 255)) & 8'hF7, acc);
    send(8'($urandom_range(0, 255)), k0);
    send(8'($urandom_range(0, 255)), k0);
    wait_until(acc + 45);
    chk("mid_frame_tx_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_residual_frame", lows, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // Loopback: random bytes with random idle gaps.
    f0 = n_frames;
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom_range(0, 255)), acc);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 150)) @(negedge clk);
    end
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (BP) @(negedge clk);
    chk("loopback_queue_drained", exp_q.size(), 32'd0);
    chk("loopback_frame_count", n_frames - f0, 32'd256);
    chk("loopback_busy_clear", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises each one onto `tx` as an 8N1 frame. Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. Sits between on-chip byte producers (command/status reporting) and the board TX pin. Its line timing matches the team's receiver at the same `CLK_FREQ`/`BAUD_RATE`.

## Interface
- `CLK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bits/s.
  - `BIT_PERIOD = CLK_FREQ / BAUD_RATE`, integer division, truncated.
  - Legal only if `BIT_PERIOD >= 2`.
- `FIFO_DEPTH`, 4: byte buffer depth; power of two, at least 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data` in 8: byte to send; sampled only when `valid && ready`.
- `valid` in 1: producer offers `data` this cycle.
- `ready` out 1: FIFO not full. Reset value 1.
- `tx` out 1: serial line, idle high, registered. Reset value 1.
- `busy` out 1: frame in progress or FIFO non-empty. Reset value 0.

## Operation
- **Push:** at an edge where `valid && ready`, `data` is written to the FIFO.
  - `ready` is derived from the registered FIFO count only, never from the same-cycle pop.
  - When the FIFO is full, a push is refused even if a pop happens that cycle.
  - `valid` while `ready`=0 is ignored; no data is lost internally, and the producer must hold.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty: pop the head byte into the shift register, clear the bit counter and the bit index, and go to START.
  - **START:** `tx`=0 for `BIT_PERIOD` cycles, then go to DATA with index 0.
  - **DATA:** `tx`=shift[0] for `BIT_PERIOD` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - **STOP:** `tx`=1 for `BIT_PERIOD` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle cycle); otherwise go to IDLE.
- **Bit counter:** width `$clog2(BIT_PERIOD)`. Counts 0..`BIT_PERIOD`-1, wraps to 0 at each bit boundary, and never exceeds the terminal value.
- **Bit index:** 3 bits, valid only in DATA.
- **`busy`:** 1 whenever the state is not IDLE or the FIFO count is non-zero.
- **FIFO:** read/write pointers of width `$clog2(FIFO_DEPTH)` wrap naturally. Count width is `$clog2(FIFO_DEPTH)+1`.
  - Simultaneous push and pop with the FIFO neither empty nor full: count is unchanged and both pointers advance.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous), the frame is abandoned, the FIFO is emptied, and the state returns to IDLE.

## Timing
- **Latency:** a byte accepted at edge k into an empty FIFO with the FSM in IDLE:
  - FIFO visible after edge k.
  - FSM pops at edge k+1.
  - `tx` falls at edge k+1.
- **Frame length:** exactly `10*BIT_PERIOD` cycles from the `tx` fall to the end of the stop bit.
- **Back-to-back frames:** a continuous stream has frame period exactly `10*BIT_PERIOD` cycles with no gap.
- **`ready` recovery:** `ready` rises the cycle after a pop from a full FIFO.
- **Glitches:** `tx` changes only on clock edges, except for the asynchronous reset assertion.

## Structure
- **Package `uart_pkg`:**
  - state enum (IDLE/START/DATA/STOP)
  - `UART_DATA_BITS`=8
  - `UART_FRAME_BITS`=10
  - a function `bit_period(clk_freq, baud)` shared with the receiver
- **Sub-module `uart_tx_fifo`:** a synchronous FIFO, parameterised width/depth. It exposes `full`, `empty`, `push`, `pop`, `wdata`, `rdata`, where `rdata` is the head, valid while not empty.
- **Top level:** the FSM, bit counter and shift register live in `uart_tx`.

## Test plan
Bench parameters: `CLK_FREQ`=1000000 and `BAUD_RATE`=100000 (`BIT_PERIOD`=10).

- **Reset state:** assert `reset` → `tx`=1, `ready`=1, `busy`=0.
- **Single byte:** push 0xA5 from idle → `tx` falls 1 cycle after the accept. Bits are 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each held 10 cycles. `busy` drops after 100 cycles.
- **Fill and back-to-back:** push 0x00,0xFF,0x55,0x0F,0xC3 continuously → the first is popped immediately and the next 4 fill the FIFO. `ready`=0 until the first stop bit ends. Five frames run gap-free over 500 cycles and are decoded correctly.
- **Full with simultaneous pop:** hold `valid` while the FIFO is full across a pop edge → no byte is accepted on that edge; it is accepted on the next.
- **Reset mid-frame:** assert `reset` during data bit 3 with 2 bytes queued → `tx`=1 at once and `busy`=0. After release, no residual frame is sent.
- **Loopback:** feed `tx` into the receiver with 256 random bytes → all received in order and intact.
